spi_mem_master: RTL

SPI_MEM_MASTER -- requirements
Module: spi_mem_master

---
 rtl/spi_mem_master.sv | 124 ++++++++++++
 1 files changed

// File: rtl/spi_mem_master.sv
// SPI mode-0 master for a flash/RAM pair sharing one bus: command, 24-bit address,
// then 1..4 data bytes. Flash writes are refused with a single-cycle err/done.
module spi_mem_master #(
    parameter int CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        sel,
    input  logic        we,
    input  logic [23:0] addr,
    input  logic [1:0]  len,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        flash_cs_n,
    output logic        ram_cs_n,
    output logic        spi_sclk,
    output logic        spi_mosi,
    input  logic        spi_miso
);
    typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, FINISH} state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t      state;
    logic        we_q;
    logic [1:0]  len_q;
    logic [63:0] tx_sh;
    logic [6:0]  rx_byte;
    logic [5:0]  bit_cnt;
    logic [7:0]  div_cnt;
    logic [63:0] frame;
    logic [5:0]  bit_last;

    assign frame    = {(we ? 8'h02 : 8'h03), addr,
                       wdata[7:0], wdata[15:8], wdata[23:16], wdata[31:24]};
    assign bit_last = 6'({1'b0, len_q, 3'b111}) + 6'd32;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            rdata      <= '0;
            flash_cs_n <= 1'b1;
            ram_cs_n   <= 1'b1;
            spi_sclk   <= 1'b0;
            spi_mosi   <= 1'b0;
            we_q       <= 1'b0;
            len_q      <= '0;
            tx_sh      <= '0;
            rx_byte    <= '0;
            bit_cnt    <= '0;
            div_cnt    <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        rdata <= '0;
                        we_q  <= we;
                        len_q <= len;
                        busy  <= 1'b1;
                        if (!sel && we) begin
                            done  <= 1'b1;
                            err   <= 1'b1;
                            state <= FINISH;
                        end else begin
                            flash_cs_n <= sel;
                            ram_cs_n   <= ~sel;
                            spi_mosi   <= frame[63];
                            tx_sh      <= {frame[62:0], 1'b0};
                            bit_cnt    <= '0;
                            div_cnt    <= '0;
                            spi_sclk   <= 1'b0;
                            state      <= CMD;
                        end
                    end
                end
                CMD, ADDR, DATA: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt  <= '0;
                        spi_sclk <= ~spi_sclk;
                        if (!spi_sclk) begin
                            // Rising SCLK: sample MISO; data bit index within the
                            // data phase is just bit_cnt[4:0] since the phase starts at 32.
                            if (state == DATA && !we_q) begin
                                rx_byte <= {rx_byte[5:0], spi_miso};
                                if (bit_cnt[2:0] == 3'd7)
                                    rdata[{bit_cnt[4:3], 3'b000} +: 8] <= {rx_byte, spi_miso};
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 6'd1;
                            if (bit_cnt == bit_last) begin
                                flash_cs_n <= 1'b1;
                                ram_cs_n   <= 1'b1;
                                spi_mosi   <= 1'b0;
                                done       <= 1'b1;
                                state      <= FINISH;
                            end else begin
                                spi_mosi <= tx_sh[63];
                                tx_sh    <= {tx_sh[62:0], 1'b0};
                                if (bit_cnt == 6'd7)  state <= ADDR;
                                if (bit_cnt == 6'd31) state <= DATA;
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                FINISH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
